// File: rtl/if_id_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_pipe_reg_pkg
// Description : Shared widths, NOP encoding and pipe-register state encoding
//               for the IF/ID pipeline register of the RV32I core.
// Revision    : 1.0  initial release
// ============================================================================
package if_id_pipe_reg_pkg;

    localparam int          DEF_INSTRUCTION_WIDTH = 32;
    localparam int          DEF_PC_WIDTH          = 32;
    // addi x0,x0,0 -- presented to decode whenever no beat is valid
    localparam logic [31:0] DEF_NOP_INST          = 32'h0000_0013;

    // EMPTY: nothing held; FULL: main entry valid; SKID: main and skid valid
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b11
    } pipe_state_e;

endpackage : if_id_pipe_reg_pkg
`default_nettype wire

// File: rtl/if_id_pipe_reg_pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_buf
// Description : Width-parameterised valid/ready register with a one-entry
//               skid buffer and a synchronous flush. in_ready comes straight
//               from the state register, so there is no combinational path
//               from out_ready back to in_ready.
// Ports       : clk, rst_n (async, active low)
//               in_valid/in_ready/in_data    upstream handshake and payload
//               flush                        drop every held/incoming beat
//               out_valid/out_ready/out_data downstream handshake and payload
// Revision    : 1.0  initial release
// ============================================================================
module pipe_skid_buf
    import if_id_pipe_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    pipe_state_e      r_state_q;
    pipe_state_e      w_state_d;
    logic [WIDTH-1:0] r_main_data_q;
    logic [WIDTH-1:0] w_main_data_d;
    logic [WIDTH-1:0] r_skid_data_q;
    logic [WIDTH-1:0] w_skid_data_d;
    logic             w_up_fire;
    logic             w_dn_fire;

    assign out_valid = (r_state_q != EMPTY);
    assign in_ready  = (r_state_q != SKID);
    assign out_data  = r_main_data_q;

    assign w_up_fire = in_valid  & in_ready;
    assign w_dn_fire = out_valid & out_ready;

    always_comb begin
        w_state_d     = r_state_q;
        w_main_data_d = r_main_data_q;
        w_skid_data_d = r_skid_data_q;

        // Flush wins over everything. A beat consumed downstream in the same
        // cycle has already been seen by decode; all else is dropped and the
        // payload registers are left untouched so id_pc keeps its last value.
        if (flush) begin
            w_state_d = EMPTY;
        end else begin
            case (r_state_q)
                EMPTY: begin
                    if (w_up_fire) begin
                        w_state_d     = FULL;
                        w_main_data_d = in_data;
                    end
                end
                FULL: begin
                    if (w_up_fire && w_dn_fire) begin
                        w_main_data_d = in_data;
                    end else if (w_up_fire) begin
                        // Decode stalled: park the new beat behind main
                        w_state_d     = SKID;
                        w_skid_data_d = in_data;
                    end else if (w_dn_fire) begin
                        w_state_d     = EMPTY;
                    end
                end
                SKID: begin
                    if (w_dn_fire) begin
                        w_state_d     = FULL;
                        w_main_data_d = r_skid_data_q;
                    end
                end
                default: begin
                    w_state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q     <= EMPTY;
            r_main_data_q <= '0;
            r_skid_data_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_main_data_q <= w_main_data_d;
            r_skid_data_q <= w_skid_data_d;
        end
    end

endmodule : pipe_skid_buf
`default_nettype wire

// File: rtl/if_id_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_pipe_reg
// Description : IF/ID pipeline register. Captures {pc, pc+4, inst} from fetch
//               under valid/ready, holds it stable while decode stalls (skid
//               buffer keeps if_ready registered) and drops in-flight beats on
//               a branch/jump flush. id_inst reads as a NOP when not valid.
// Ports       : clk, reset (async, active low)
//               if_valid/if_ready, if_pc, if_pc_plus_4, if_inst  fetch side
//               flush                                            redirect
//               id_valid/id_ready, id_pc, id_pc_plus_4, id_inst  decode side
// Revision    : 1.0  initial release
// ============================================================================
module if_id_pipe_reg
    import if_id_pipe_reg_pkg::*;
#(
    parameter int                           INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
    parameter int                           PC_WIDTH          = DEF_PC_WIDTH,
    parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INST          = DEF_NOP_INST
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         if_valid,
    output logic                         if_ready,
    input  logic [PC_WIDTH-1:0]          if_pc,
    input  logic [PC_WIDTH-1:0]          if_pc_plus_4,
    input  logic [INSTRUCTION_WIDTH-1:0] if_inst,
    input  logic                         flush,
    output logic                         id_valid,
    input  logic                         id_ready,
    output logic [PC_WIDTH-1:0]          id_pc,
    output logic [PC_WIDTH-1:0]          id_pc_plus_4,
    output logic [INSTRUCTION_WIDTH-1:0] id_inst
);

    localparam int PAYLOAD_W = 2 * PC_WIDTH + INSTRUCTION_WIDTH;

    logic [PAYLOAD_W-1:0]         w_payload_in;
    logic [PAYLOAD_W-1:0]         w_payload_out;
    logic [INSTRUCTION_WIDTH-1:0] w_inst;

    assign w_payload_in = {if_pc, if_pc_plus_4, if_inst};

    pipe_skid_buf #(
        .WIDTH     (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (reset),
        .in_valid  (if_valid),
        .in_ready  (if_ready),
        .in_data   (w_payload_in),
        .flush     (flush),
        .out_valid (id_valid),
        .out_ready (id_ready),
        .out_data  (w_payload_out)
    );

    assign {id_pc, id_pc_plus_4, w_inst} = w_payload_out;

    // Decode must never see a stale instruction on a bubble
    assign id_inst = id_valid ? w_inst : NOP_INST;

endmodule : if_id_pipe_reg
`default_nettype wire

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
- Pipeline register between the instruction fetch unit (IF_unit) and the decode stage of the RV32I core.
- Captures fetch outputs (pc_out, pc_plus_4, inst) under a valid/ready handshake.
- Holds the captured beat stable while decode stalls, using a one-entry skid buffer so if_ready is registered.
- Discards in-flight instructions when a taken branch or jump (PCSel) flushes the pipe.

Parameters:
- INSTRUCTION_WIDTH, 32, width of the instruction word.
- PC_WIDTH, 32, width of the PC and PC+4 values.
- NOP_INST, 32'h00000013, encoding driven on id_inst whenever id_valid=0 (addi x0,x0,0).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- if_valid  input  1  fetch presents a valid beat.
- if_ready  output  1  this block can accept a beat; registered, equals !skid_valid.
- if_pc  input  PC_WIDTH  PC of the fetched instruction (from pc_out).
- if_pc_plus_4  input  PC_WIDTH  PC+4 from fetch.
- if_inst  input  INSTRUCTION_WIDTH  fetched instruction.
- flush  input  1  discard all held and incoming beats (driven from PCSel/redirect).
- id_valid  output  1  decode-side beat valid.
- id_ready  input  1  decode accepts the beat.
- id_pc  output  PC_WIDTH  PC to decode.
- id_pc_plus_4  output  PC_WIDTH  PC+4 to decode.
- id_inst  output  INSTRUCTION_WIDTH  instruction to decode; NOP_INST when id_valid=0.

Behaviour:
- Storage: main entry (main_valid, pc, pc4, inst) drives the id_* outputs; skid entry (skid_valid, pc, pc4, inst).
- Handshake signals: up_fire = if_valid & if_ready; dn_fire = id_valid & id_ready.
- Reset (reset=0, async): main_valid=0, skid_valid=0, id_valid=0, if_ready=1, id_pc=0, id_pc_plus_4=0, id_inst=NOP_INST, all skid fields 0.
- State EMPTY (!main_valid, !skid_valid):
  - up_fire -> FULL; main loads if_*.
- State FULL (main_valid, !skid_valid):
  - up_fire & dn_fire -> FULL; main loads if_* (full throughput, 1 beat/cycle).
  - up_fire & !dn_fire -> SKID; skid loads if_*, main holds.
  - !up_fire & dn_fire -> EMPTY.
  - neither -> hold.
- State SKID (main_valid, skid_valid):
  - if_ready=0, so no up_fire is possible.
  - dn_fire -> FULL; main loads skid contents, skid_valid clears.
  - otherwise hold.
- Latency: a beat accepted at edge N is visible on id_* with id_valid=1 after edge N (one cycle).
- Stability: while id_valid=1 and id_ready=0, id_pc, id_pc_plus_4 and id_inst do not change.
- Ordering: beats leave in acceptance order; none is dropped or duplicated except by flush.
- Flush (synchronous, highest priority):
  - next state EMPTY; main_valid=0 and skid_valid=0.
  - Any beat offered the same cycle (up_fire) is discarded.
  - id_valid=0 on the following cycle; if_ready=1 on the following cycle.
- Flush with dn_fire in the same cycle: decode consumes the current beat (it was issued before the redirect); everything else is discarded.
- id_inst is muxed to NOP_INST whenever id_valid=0. id_pc and id_pc_plus_4 hold their last values when empty.
- Reset asserted mid-operation clears everything immediately, independent of clk.
- No arithmetic: PC+4 is passed through, never recomputed.

Decomposition:
- Shared package/defines (defines.vh): INSTRUCTION_WIDTH, PC_WIDTH, NOP_INST, and state encodings EMPTY=2'b00, FULL=2'b01, SKID=2'b11.
- One natural sub-module: pipe_skid_buf, a generic width-parameterised valid/ready register with skid entry and flush.
  - if_id_pipe_reg instantiates it with a concatenated {pc, pc4, inst} payload and adds the NOP output mux.

Test Plan:
- Reset: hold reset=0 for 12 ns with if_valid=1 -> id_valid=0, id_inst=32'h00000013, if_ready=1; after release, first beat (pc=0x0, inst=0x00500093) appears on id_* one cycle after acceptance.
- Streaming: id_ready=1, fetch pc 0x0/0x4/0x8 on consecutive cycles -> id_pc follows 0x0,0x4,0x8 one cycle later; if_ready stays 1; no bubbles.
- Stall/skid: id_ready=0 while beats at pc 0x4 and 0x8 arrive -> id_pc holds 0x4, if_ready drops to 0 after 0x8 is accepted; id_ready=1 -> 0x4 then 0x8 delivered in order, if_ready returns to 1.
- Flush: while in SKID (0x4 held, 0x8 in skid), pulse flush with if_valid=1 and pc=0xC (from_alu=0xC) -> next cycle id_valid=0, id_inst=NOP; the next accepted beat (pc=0xC) is the first output.
- Flush with dn_fire: FULL with pc=0x10, id_ready=1, flush=1 -> 0x10 consumed once; no later beat from before the flush appears.
- Async reset mid-stall: assert reset=0 between clock edges while in SKID -> id_valid and skid cleared immediately (before the next edge), if_ready=1.
